lcd_stream_writer: RTL
======================

Name: lcd_stream_writer

Overview:
Parametrised HD44780 4-bit-bus writer, the successor to the team's fixed-timing LCD writer. It accepts a single nibble, a single byte, or a string of up to MAX_BYTES bytes through a start/busy/done handshake. It drives RS, the data nibble and the enable strobe with programmable setup, pulse, gap and execution-wait timing. It sits between the LCD init/control FSM and the LCD pins, and owns its enable timing internally.

Parameters:
MAX_BYTES, 16, maximum string length in bytes; width of iPhrase is 8*MAX_BYTES.
SETUP_CYC, 2, cycles that RS/data are stable before enable rises.
EN_PULSE_CYC, 12, enable high time in cycles.
NIBBLE_GAP_CYC, 50, enable-low gap between the upper and lower nibble of one byte.
CMD_WAIT_CYC, 2000, wait after the last nibble of a normal byte, or after a single nibble.
LONG_WAIT_CYC, 82000, wait after command byte 0x01, 0x02 or 0x03 (clear/home).
CNT_W, 32, width of the delay counter; must hold the largest cycle parameter.

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
iStart  in  1  start request, sampled only in IDLE.
iMode  in  2  0 = nibble, 1 = byte, 2 = string, 3 = reserved.
iRS  in  1  register select (0 = command, 1 = data), applied to the whole transfer.
iNibble  in  4  payload for mode 0.
iByte  in  8  payload for mode 1.
iPhrase  in  8*MAX_BYTES  payload for mode 2; byte 0 is bits [7:0] and is sent first.
iLength  in  $clog2(MAX_BYTES+1)  number of bytes for mode 2.
oBusy  out  1  transfer in progress.
oDone  out  1  one-cycle completion pulse.
oData  out  4  LCD DB[7:4].
oRS  out  1  LCD RS.
oRW  out  1  LCD R/W; constant 0.
oEnable  out  1  LCD E.

Behaviour:
- Reset: async clear. State = IDLE; all outputs 0; counters and shift register 0. Asserting reset mid-transfer aborts immediately: oEnable drops and no oDone is issued.
- Capture on acceptance: at the rising edge where state = IDLE and iStart = 1, the block latches iMode, iRS, payload and length (clamped to MAX_BYTES). oBusy = 1 from that edge.
- Inputs not sampled while busy: iStart and the payload inputs are ignored until the block returns to IDLE.
- States: IDLE, SETUP, EN_HIGH, GAP, EXEC_WAIT, NEXT, DONE.
- SETUP: drive oRS and oData (current nibble) for SETUP_CYC cycles, enable low.
- EN_HIGH: oEnable = 1 for EN_PULSE_CYC cycles; data held.
- GAP: entered after the upper nibble of a byte. Enable low, data held, for NIBBLE_GAP_CYC cycles, then SETUP with the lower nibble.
- EXEC_WAIT: entered after the lower nibble, or after the single nibble in mode 0. Waits CMD_WAIT_CYC cycles, or LONG_WAIT_CYC cycles when RS = 0 and the byte is 0x01, 0x02 or 0x03. Mode 0 always uses CMD_WAIT_CYC.
- NEXT: in mode 2, shift the latched phrase right by 8 and decrement the remaining count. If the count is nonzero, go to SETUP; otherwise go to DONE. NEXT takes 0 cycles: it is combinational within the last EXEC_WAIT cycle.
- DONE: oDone = 1 and oBusy = 0 on the same cycle, then IDLE. iStart may be accepted on the cycle after oDone.
- Total busy cycles, with S = SETUP_CYC, E = EN_PULSE_CYC, G = NIBBLE_GAP_CYC:
  - mode 0: S+E+CMD_WAIT_CYC
  - mode 1: 2S+2E+G+W, where W is the applicable wait
  - mode 2: sum of the mode 1 figure over each byte
- Zero-length string: mode 2 with iLength = 0 gives oBusy for exactly 1 cycle and then oDone, with no enable pulse.
- Reserved mode: mode 3 behaves the same as a zero-length string.
- Oversize string: iLength > MAX_BYTES sends MAX_BYTES bytes.
- Held outputs: oData and oRS keep their last driven values in IDLE and DONE. oEnable is never high outside EN_HIGH.
- Counter: a single down-counter of width CNT_W, loaded with (param − 1) on state entry; a state exits when the count is 0. A parameter value of 0 is illegal; parameters are ≥ 1.

Test Plan:
Bench parameters for all scenarios: S = 2, E = 3, G = 5, CMD = 10, LONG = 20, MAX_BYTES = 4.
1. Mode 1, iByte = 0x48, iRS = 1, one-cycle iStart -> oData = 4 with E high for 3 cycles, then oData = 8 with E high for 3 cycles; oRS = 1 throughout; oBusy for 25 cycles; oDone pulse on cycle 26.
2. Mode 1, iByte = 0x01, iRS = 0 -> same pulse train with a 20-cycle final wait; busy for 35 cycles. Repeat with 0x0C -> busy for 25 cycles.
3. Mode 2, iPhrase = 0x…_4F_4B (2 bytes), iLength = 2 -> nibble order 4, B, 4, F; exactly 4 enable pulses; busy for 50 cycles; one oDone pulse.
4. Mode 0, iNibble = 0x3 -> one E pulse with oData = 3; busy for 15 cycles. Mode 2 with iLength = 0 -> no E pulse, oDone after 1 busy cycle.
5. iStart held high continuously across a mode 1 transfer -> the second transfer starts only on the cycle after oDone; payload changes made while busy do not alter the output.
6. Reset driven low during EN_HIGH of scenario 3, asynchronously between clock edges -> oEnable, oBusy and oData go to 0 immediately, no oDone; after release, a new mode 1 transfer completes normally.

Source files
------------

// File: rtl/lcd_stream_writer.sv
// HD44780 4-bit bus writer: sends a nibble, a byte or a short string with
// programmable setup, enable pulse, inter-nibble gap and execution wait.
module lcd_stream_writer #(
    parameter int unsigned MAX_BYTES      = 16,
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned EN_PULSE_CYC   = 12,
    parameter int unsigned NIBBLE_GAP_CYC = 50,
    parameter int unsigned CMD_WAIT_CYC   = 2000,
    parameter int unsigned LONG_WAIT_CYC  = 82000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           iStart,
    input  logic [1:0]                     iMode,
    input  logic                           iRS,
    input  logic [3:0]                     iNibble,
    input  logic [7:0]                     iByte,
    input  logic [8*MAX_BYTES-1:0]         iPhrase,
    input  logic [$clog2(MAX_BYTES+1)-1:0] iLength,
    output logic                           oBusy,
    output logic                           oDone,
    output logic [3:0]                     oData,
    output logic                           oRS,
    output logic                           oRW,
    output logic                           oEnable
);

    localparam int unsigned PHRASE_W = 8 * MAX_BYTES;
    localparam int unsigned LEN_W    = $clog2(MAX_BYTES + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(NIBBLE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [2:0] {
        IDLE, SETUP, EN_HIGH, GAP, EXEC_WAIT, NEXT, DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [PHRASE_W-1:0] phrase;
    logic [PHRASE_W-1:0] phraseNext;
    logic [LEN_W-1:0]    remaining;
    logic [LEN_W-1:0]    lenClamped;
    logic                upperPhase;
    logic                nibbleMode;
    logic                longWait;
    logic                emptyStart;

    assign oRW = 1'b0;

    // Current byte always sits in phrase[7:0]; clear/home commands need the long wait.
    always_comb begin
        phraseNext = phrase >> 8;
        lenClamped = (iLength > LEN_MAX) ? LEN_MAX : iLength;
        emptyStart = (iMode == 2'd3) || ((iMode == 2'd2) && (lenClamped == '0));
        longWait   = !oRS && !nibbleMode &&
                     ((phrase[7:0] == 8'h01) || (phrase[7:0] == 8'h02) || (phrase[7:0] == 8'h03));
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            count      <= '0;
            phrase     <= '0;
            remaining  <= '0;
            upperPhase <= 1'b0;
            nibbleMode <= 1'b0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oData      <= '0;
            oRS        <= 1'b0;
            oEnable    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        oBusy <= 1'b1;
                        if (emptyStart) begin
                            // Nothing to send: one busy cycle in NEXT, then DONE.
                            state     <= NEXT;
                            remaining <= '0;
                        end else begin
                            state      <= SETUP;
                            count      <= SETUP_LD;
                            oRS        <= iRS;
                            nibbleMode <= (iMode == 2'd0);
                            upperPhase <= (iMode != 2'd0);
                            case (iMode)
                                2'd0: begin
                                    phrase    <= PHRASE_W'(iNibble);
                                    oData     <= iNibble;
                                    remaining <= LEN_ONE;
                                end
                                2'd1: begin
                                    phrase    <= PHRASE_W'(iByte);
                                    oData     <= iByte[7:4];
                                    remaining <= LEN_ONE;
                                end
                                default: begin
                                    phrase    <= iPhrase;
                                    oData     <= iPhrase[7:4];
                                    remaining <= lenClamped;
                                end
                            endcase
                        end
                    end
                end
                SETUP: begin
                    if (count != '0) begin
                        count <= count - CNT_W'(1);
                    end else begin
                        state   <= EN_HIGH;
                        oEnable <= 1'b1;
                        count   <= EN_LD;
                    end
                end
                EN_HIGH: begin
                    if (count != '0) begin
                        count <= count - CNT_W'(1);
                    end else begin
                        oEnable <= 1'b0;
                        if (upperPhase) begin
                            state      <= GAP;
                            count      <= GAP_LD;
                            upperPhase <= 1'b0;
                        end else begin
                            state <= EXEC_WAIT;
                            count <= longWait ? LONG_LD : CMD_LD;
                        end
                    end
                end
                GAP: begin
                    if (count != '0) begin
                        count <= count - CNT_W'(1);
                    end else begin
                        state <= SETUP;
                        count <= SETUP_LD;
                        oData <= phrase[3:0];
                    end
                end
                EXEC_WAIT: begin
                    if (count != '0) begin
                        count <= count - CNT_W'(1);
                    end else if (remaining > LEN_ONE) begin
                        // Advance to the next string byte without an extra cycle.
                        phrase     <= phraseNext;
                        remaining  <= remaining - LEN_ONE;
                        upperPhase <= 1'b1;
                        oData      <= phraseNext[7:4];
                        count      <= SETUP_LD;
                        state      <= SETUP;
                    end else begin
                        remaining <= '0;
                        state     <= DONE;
                        oBusy     <= 1'b0;
                        oDone     <= 1'b1;
                    end
                end
                NEXT: begin
                    state <= DONE;
                    oBusy <= 1'b0;
                    oDone <= 1'b1;
                end
                DONE: begin
                    oDone <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
